// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared N-bit register.
// Four requesters, a bounded hold time, and one IDLE cycle per handover.
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] wdata,
    output logic [3:0]     gnt,
    output logic [1:0]     owner,
    output logic           busy,
    output logic [N-1:0]   Q,
    output logic           wr_en
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam logic [3:0] LIMIT = 4'(MAX_HOLD - 1);

    state_t       state;
    logic [1:0]   rr_ptr;
    logic [3:0]   hold_cnt;
    logic [1:0]   sel;
    logic [1:0]   idx;
    logic         found;
    logic         others;
    logic         at_limit;
    logic [N-1:0] lane;

    // Pick the first pending requester, searching upward from rr_ptr.
    always_comb begin
        sel   = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + i[1:0];
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Write strobe, lane mux and forced-rotation conditions.
    always_comb begin
        wr_en    = gnt[owner] & req[owner];
        lane     = wdata[32'(owner)*N +: N];
        others   = |(req & ~gnt);
        at_limit = (hold_cnt == LIMIT);
    end

    // Ownership FSM; the shared register is written only while OWNED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            owner    <= 2'd0;
            busy     <= 1'b0;
            Q        <= '0;
            rr_ptr   <= 2'd0;
            hold_cnt <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWNED;
                        owner    <= sel;
                        gnt      <= 4'b0001 << sel;
                        busy     <= 1'b1;
                        hold_cnt <= 4'd0;
                    end
                end
                OWNED: begin
                    if (!req[owner]) begin
                        state  <= IDLE;
                        gnt    <= 4'b0000;
                        busy   <= 1'b0;
                        rr_ptr <= owner + 2'd1;
                    end else begin
                        Q <= lane;
                        if (at_limit) begin
                            hold_cnt <= 4'd0;
                            if (others) begin
                                state  <= IDLE;
                                gnt    <= 4'b0000;
                                busy   <= 1'b0;
                                rr_ptr <= owner + 2'd1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: scoreboard bench for shared_reg_arbiter.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_shared_reg_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [3:0]     req;
    logic [4*N-1:0] wdata;
    logic [3:0]     gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [N-1:0]   Q;
    logic           wr_en;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      nm;
        logic       wr;
        logic [3:0] gnt;
        logic       busy;
        logic [3:0] q;
    } exp_t;

    exp_t sb[$];

    shared_reg_arbiter #(.N(N), .MAX_HOLD(3)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .Q     (Q),
        .wr_en (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lanes(input logic [3:0] l0, input logic [3:0] l1,
                                          input logic [3:0] l2, input logic [3:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = i[1:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one cycle at the negedge and queue what the next edge must show.
    task automatic cyc(input logic [3:0] r, input logic [15:0] d, input logic ew,
                       input logic [3:0] eg, input logic eb, input logic [3:0] eq,
                       input string nm);
        exp_t e;
        req   = r;
        wdata = d;
        e.nm   = nm;
        e.wr   = ew;
        e.gnt  = eg;
        e.busy = eb;
        e.q    = eq;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: wr_en just before the edge, registered outputs just after.
    initial begin
        logic w;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            w = wr_en;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, "_wr"},   16'(w),    16'(e.wr));
                chk({e.nm, "_gnt"},  16'(gnt),  16'(e.gnt));
                chk({e.nm, "_busy"}, 16'(busy), 16'(e.busy));
                chk({e.nm, "_q"},    16'(Q),    16'(e.q));
                if (e.busy)
                    chk({e.nm, "_own"}, 16'(owner), 16'(idx_of(e.gnt)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ld;
        reset = 1'b1;
        req   = 4'b0000;
        wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",  16'(gnt),   16'h0);
        chk("rst_busy", 16'(busy),  16'h0);
        chk("rst_q",    16'(Q),     16'h0);
        chk("rst_own",  16'(owner), 16'h0);
        reset = 1'b0;

        // Reset behaviour, requester 0 wins ties after reset
        ld = lanes(4'h1, 4'h2, 4'h3, 4'h4);
        cyc(4'b1111, ld, 1'b0, 4'b0001, 1'b1, 4'h0, "t1_grant");
        cyc(4'b1111, ld, 1'b1, 4'b0001, 1'b1, 4'h1, "t1_write");
        #2 reset = 1'b1;
        #1;
        chk("t1_async_gnt",  16'(gnt),  16'h0);
        chk("t1_async_busy", 16'(busy), 16'h0);
        chk("t1_async_q",    16'(Q),    16'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(4'b1111, ld, 1'b0, 4'b0001, 1'b1, 4'h0, "t1_regrant");
        cyc(4'b0000, ld, 1'b0, 4'b0000, 1'b0, 4'h0, "t1_drop");

        // Single requester 2, rr_ptr ends at 3
        ld = lanes(4'h0, 4'h0, 4'hA, 4'h0);
        cyc(4'b0100, ld, 1'b0, 4'b0100, 1'b1, 4'h0, "t2_grant");
        cyc(4'b0100, ld, 1'b1, 4'b0100, 1'b1, 4'hA, "t2_write");
        cyc(4'b0000, ld, 1'b0, 4'b0000, 1'b0, 4'hA, "t2_rel");
        cyc(4'b1111, ld, 1'b0, 4'b1000, 1'b1, 4'hA, "t2_rr3");
        cyc(4'b0000, ld, 1'b0, 4'b0000, 1'b0, 4'hA, "t2_drop");

        // Forced rotation after three writes
        cyc(4'b0011, lanes(4'h1, 4'hF, 4'h0, 4'h0), 1'b0, 4'b0001, 1'b1, 4'hA, "t3_grant");
        cyc(4'b0011, lanes(4'h1, 4'hF, 4'h0, 4'h0), 1'b1, 4'b0001, 1'b1, 4'h1, "t3_w1");
        cyc(4'b0011, lanes(4'h2, 4'hF, 4'h0, 4'h0), 1'b1, 4'b0001, 1'b1, 4'h2, "t3_w2");
        cyc(4'b0011, lanes(4'h3, 4'hF, 4'h0, 4'h0), 1'b1, 4'b0000, 1'b0, 4'h3, "t3_w3");
        cyc(4'b0011, lanes(4'h4, 4'hF, 4'h0, 4'h0), 1'b0, 4'b0010, 1'b1, 4'h3, "t3_idle");
        cyc(4'b0011, lanes(4'h4, 4'hF, 4'h0, 4'h0), 1'b1, 4'b0010, 1'b1, 4'hF, "t3_own1");
        cyc(4'b0000, lanes(4'h4, 4'hF, 4'h0, 4'h0), 1'b0, 4'b0000, 1'b0, 4'hF, "t3_drop");

        // Sole owner keeps the grant past the hold limit
        cyc(4'b1000, lanes(4'h0, 4'h0, 4'h0, 4'h0), 1'b0, 4'b1000, 1'b1, 4'hF, "t4_grant");
        for (int k = 0; k < 8; k++)
            cyc(4'b1000, lanes(4'h0, 4'h0, 4'h0, 4'(k)), 1'b1, 4'b1000, 1'b1, 4'(k),
                $sformatf("t4_w%0d", k));
        cyc(4'b0000, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t4_drop");

        // Round-robin order 0,1,2,3,0 with owners dropping after each grant
        cyc(4'b1111, ld, 1'b0, 4'b0001, 1'b1, 4'h7, "t5_g0");
        cyc(4'b1110, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t5_r0");
        cyc(4'b1111, ld, 1'b0, 4'b0010, 1'b1, 4'h7, "t5_g1");
        cyc(4'b1101, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t5_r1");
        cyc(4'b1111, ld, 1'b0, 4'b0100, 1'b1, 4'h7, "t5_g2");
        cyc(4'b1011, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t5_r2");
        cyc(4'b1111, ld, 1'b0, 4'b1000, 1'b1, 4'h7, "t5_g3");
        cyc(4'b0111, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t5_r3");
        cyc(4'b1111, ld, 1'b0, 4'b0001, 1'b1, 4'h7, "t5_g0b");

        // Reset pulse while owner 1 is about to write 5
        ld = lanes(4'h0, 4'h5, 4'h0, 4'h0);
        cyc(4'b0010, ld, 1'b0, 4'b0000, 1'b0, 4'h7, "t6_rel");
        cyc(4'b0010, ld, 1'b0, 4'b0010, 1'b1, 4'h7, "t6_grant");
        #1;
        chk("t6_wr_pending", 16'(wr_en), 16'h1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_gnt",  16'(gnt),  16'h0);
        chk("t6_rst_busy", 16'(busy), 16'h0);
        chk("t6_rst_q",    16'(Q),    16'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_regrant", 16'(gnt), 16'b0010);
        chk("t6_no5_q",   16'(Q),   16'h0);
        cyc(4'b0000, ld, 1'b0, 4'b0000, 1'b0, 4'h0, "t6_end");

        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin scheduler that shares one N-bit storage register between four write requesters. Each requester raises a request with its data. The block grants exactly one owner at a time and writes the owner's data into the register. It also forces rotation after MAX_HOLD consecutive writes when another requester is waiting. It sits in front of the team's structural D-flip-flop register and is the only writer of it.

## Interface
- N, 4: data width of the shared register and of each write lane.
- MAX_HOLD, 3: maximum consecutive write cycles one owner may keep the grant while another request is pending; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request; req[i] is level, held until served or withdrawn.
- wdata  input  4*N  packed write lanes; lane i is wdata[i*N +: N].
- gnt  output  4  registered one-hot grant (all zero when idle).
- owner  output  2  index of current owner; valid while busy=1.
- busy  output  1  1 while in state OWNED.
- Q  output  N  contents of the shared register.
- wr_en  output  1  combinational; equals gnt[owner] & req[owner]; the register loads on this cycle's edge.

## Operation
- Reset (async, immediate): state=IDLE, gnt=0, owner=0, busy=0, Q=0, rr_ptr=0, hold_cnt=0.
- State IDLE:
  - If req != 0, select the first set bit searching rr_ptr, rr_ptr+1, ... mod 4.
  - Next state is OWNED with owner=selected, gnt=one-hot(selected) and hold_cnt=0.
  - No write occurs in IDLE.
- State OWNED:
  - When wr_en=1, Q <= lane[owner] and hold_cnt <= hold_cnt+1.
  - Release if req[owner]=0:
    - Next state IDLE, gnt=0.
    - rr_ptr <= owner+1 mod 4.
    - No write that cycle.
  - Forced release if wr_en=1, hold_cnt = MAX_HOLD-1 and any other req bit is set:
    - The write this cycle still happens.
    - Next state IDLE, gnt=0, rr_ptr <= owner+1 mod 4.
  - If hold_cnt = MAX_HOLD-1 and no other req is pending, the owner keeps the grant and hold_cnt is cleared to 0, so the limit applies again from that point.
  - Other requests arriving while OWNED are ignored until the next IDLE cycle.
- Every handover passes through one IDLE cycle. Grant and release are both registered, so there is never overlap or a glitch on gnt.
- Q holds its value whenever wr_en=0. It is never written in IDLE.
- owner holds its last value in IDLE; busy=0 marks it stale.

## Timing
- Grant latency: req[i] sampled high in IDLE at edge k gives gnt[i]=1 after edge k. The first write lands at edge k+1, so Q shows the new data after edge k+1.
- Request-to-Q latency is 2 cycles minimum.
- Steady ownership gives one write per cycle. Q follows lane[owner] with 1-cycle latency.
- Release: req[owner] dropping before edge m gives gnt=0 after edge m, and IDLE lasts one cycle.
- The next grant is visible after edge m+1.
- Forced rotation: the owner gets MAX_HOLD writes, then one IDLE cycle, then the next requester in round-robin order is granted.
- Simultaneous requests in IDLE: the search order from rr_ptr decides. After reset, requester 0 wins ties.
- Reset asserted mid-OWNED: gnt and busy drop immediately with no clock, and Q=0. The in-flight write is discarded.
- Requesters must hold wdata stable while gnt=1. Lane data is sampled only on wr_en edges.

## Test plan
- Reset: assert reset mid-cycle with req=4'b1111 -> gnt=0, busy=0 and Q=0 immediately. After release, the first grant is gnt=4'b0001.
- Single requester: req=4'b0100, lane2=4'hA for 1 write cycle then drop -> gnt=4'b0100 after edge 1, Q=4'hA after edge 2, gnt=0 after edge 3, rr_ptr=3.
- Forced rotation, MAX_HOLD=3: req=4'b0011, lane0 counting 1,2,3,4, lane1=4'hF -> Q=1,2,3 while gnt=4'b0001, then one IDLE cycle, then gnt=4'b0010 and Q=4'hF.
- Sole owner, no limit: req=4'b1000 held 8 cycles, lane3 counting 0..7 -> gnt stays 4'b1000 with no IDLE gap. Q tracks lane3 delayed 1 cycle through all 8 writes.
- Round-robin fairness: req=4'b1111 held, each owner drops its req for one cycle after each of its grants -> grant order is 0,1,2,3,0. wr_en=0 on every IDLE cycle.
- Reset mid-ownership: owner=1 writing 4'h5 and reset pulses between edges -> Q=0, gnt=0. The write of 4'h5 never appears on Q.
